pid_ctrl_p: RTL and testbench

Parametrised PID steering controller for the Knight's Tour drive path. It converts a signed heading error and a forward-speed command into registered, saturated left and right wheel speeds for the motor driver. It generalises the fixed-width PID with three additions: configurable widths and gains, a configurable-depth derivative history, and integrator overflow hold. It also adds an explicit output-valid strobe. It sits between the heading-error source and `mtr_drv`.

---
 rtl/pid_pkg.sv | 33 +++
 rtl/pid_sat.sv | 23 ++
 rtl/pid_ctrl_p.sv | 174 +++++++++++++++++
 tb/tb_pid_ctrl_p.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared constants and the signed saturation helper for the PID steering controller.
package pid_pkg;

    localparam int ERR_W_DEF   = 12;
    localparam int SAT_W_DEF   = 10;
    localparam int FRWRD_W_DEF = 10;
    localparam int SPD_W_DEF   = 11;
    localparam int P_COEFF_DEF = 3;
    localparam int D_COEFF_DEF = 14;
    localparam int D_SAT_W_DEF = 7;
    localparam int D_DEPTH_DEF = 1;
    localparam int INTG_W_DEF  = 18;
    localparam int I_SHIFT_DEF = 6;

    // The summed PID value is divided by 8 before it steers the wheels.
    localparam int OUT_SHIFT = 3;

    // Clamp a sign-extended value into the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Parametrised combinational signed saturator from IN_W bits down (or up) to OUT_W bits.
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

    logic signed [63:0] wide_in;
    logic signed [63:0] wide_out;
    logic               unused_hi;

    assign wide_in  = {{(64-IN_W){din_i[IN_W-1]}}, din_i};
    assign wide_out = sat_signed(wide_in, OUT_W);
    assign dout_o   = wide_out[OUT_W-1:0];

    // After clamping, the upper bits are just copies of the sign bit.
    assign unused_hi = ^wide_out[63:OUT_W];

endmodule

// File: rtl/pid_ctrl_p.sv
// PID steering controller: heading error + forward command -> saturated wheel speeds.
// Optional macro PID_PIPE_EN registers the PID sum ahead of the output stage.
module pid_ctrl_p
    import pid_pkg::*;
#(
    parameter int ERR_W   = ERR_W_DEF,
    parameter int SAT_W   = SAT_W_DEF,
    parameter int FRWRD_W = FRWRD_W_DEF,
    parameter int SPD_W   = SPD_W_DEF,
    parameter int P_COEFF = P_COEFF_DEF,
    parameter int D_COEFF = D_COEFF_DEF,
    parameter int D_SAT_W = D_SAT_W_DEF,
    parameter int D_DEPTH = D_DEPTH_DEF,
    parameter int INTG_W  = INTG_W_DEF,
    parameter int I_SHIFT = I_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [FRWRD_W-1:0]      frwrd,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld
);

    localparam int TW = SAT_W + 4;
    localparam int DW = SAT_W + 1;
    localparam int IW = INTG_W - I_SHIFT;
    localparam int OW = ((FRWRD_W + 1 > TW) ? FRWRD_W + 1 : TW) + 1;

    localparam logic signed [TW-1:0] P_K = TW'(P_COEFF);
    localparam logic signed [TW-1:0] D_K = TW'(D_COEFF);

    logic signed [SAT_W-1:0]   err_sat;
    logic signed [SAT_W-1:0]   hist_q [D_DEPTH];
    logic signed [SAT_W-1:0]   hist_last;
    logic signed [DW-1:0]      d_diff;
    logic signed [D_SAT_W-1:0] d_sat;

    logic signed [TW-1:0]      p_q, p_d;
    logic signed [TW-1:0]      i_q, i_d;
    logic signed [TW-1:0]      d_q, d_d;
    logic signed [INTG_W-1:0]  intg_q, intg_d;
    logic signed [INTG_W-1:0]  err_ext;
    logic signed [INTG_W-1:0]  intg_sum;
    logic                      intg_ovf;
    logic                      vld_q;

    logic signed [TW-1:0]      pid;
    logic signed [TW-1:0]      pid_s;
    logic [FRWRD_W-1:0]        frwrd_s;
    logic                      moving_s;
    logic                      vld_s;
    logic signed [TW-1:0]      drive;
    logic signed [OW-1:0]      fr_ext;
    logic signed [OW-1:0]      drv_ext;
    logic signed [OW-1:0]      out_sum [2];
    logic signed [SPD_W-1:0]   out_sat [2];

    pid_sat #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_err_sat (
        .din_i  (error),
        .dout_o (err_sat)
    );

    // Derivative compares against the sample D_DEPTH accepted errors ago.
    assign hist_last = hist_q[D_DEPTH-1];
    assign d_diff    = {err_sat[SAT_W-1], err_sat} - {hist_last[SAT_W-1], hist_last};

    pid_sat #(.IN_W(DW), .OUT_W(D_SAT_W)) u_d_sat (
        .din_i  (d_diff),
        .dout_o (d_sat)
    );

    assign p_d = {{(TW-SAT_W){err_sat[SAT_W-1]}}, err_sat} * P_K;
    assign d_d = {{(TW-D_SAT_W){d_sat[D_SAT_W-1]}}, d_sat} * D_K;
    assign i_d = {{(TW-IW){intg_q[INTG_W-1]}}, intg_q[INTG_W-1:I_SHIFT]};

    assign err_ext  = {{(INTG_W-SAT_W){err_sat[SAT_W-1]}}, err_sat};
    assign intg_sum = intg_q + err_ext;
    assign intg_ovf = (intg_q[INTG_W-1] == err_ext[INTG_W-1]) &&
                      (intg_sum[INTG_W-1] != intg_q[INTG_W-1]);

    always_comb begin
        intg_d = intg_q;
        if (!moving) begin
            intg_d = '0;
        end else if (err_vld && !intg_ovf) begin
            intg_d = intg_sum;
        end
    end

    assign pid = p_q + i_q + d_q;

`ifdef PID_PIPE_EN
    logic signed [TW-1:0] pid_q;
    logic [FRWRD_W-1:0]   frwrd_q;
    logic                 moving_q;
    logic                 vld_pipe_q;

    // frwrd and moving ride alongside pid so all output inputs stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q      <= '0;
            frwrd_q    <= '0;
            moving_q   <= 1'b0;
            vld_pipe_q <= 1'b0;
        end else begin
            pid_q      <= pid;
            frwrd_q    <= frwrd;
            moving_q   <= moving;
            vld_pipe_q <= vld_q;
        end
    end

    assign pid_s    = pid_q;
    assign frwrd_s  = frwrd_q;
    assign moving_s = moving_q;
    assign vld_s    = vld_pipe_q;
`else
    assign pid_s    = pid;
    assign frwrd_s  = frwrd;
    assign moving_s = moving;
    assign vld_s    = vld_q;
`endif

    assign drive      = pid_s >>> OUT_SHIFT;
    assign fr_ext     = {{(OW-FRWRD_W){1'b0}}, frwrd_s};
    assign drv_ext    = {{(OW-TW){drive[TW-1]}}, drive};
    assign out_sum[0] = fr_ext + drv_ext;
    assign out_sum[1] = fr_ext - drv_ext;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_spd_sat
            pid_sat #(.IN_W(OW), .OUT_W(SPD_W)) u_spd_sat (
                .din_i  (out_sum[gi]),
                .dout_o (out_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            i_q      <= '0;
            d_q      <= '0;
            intg_q   <= '0;
            vld_q    <= 1'b0;
            spd_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            vld_q   <= err_vld;
            spd_vld <= vld_s;
            intg_q  <= intg_d;
            if (err_vld) begin
                p_q       <= p_d;
                i_q       <= i_d;
                d_q       <= d_d;
                hist_q[0] <= err_sat;
                for (int i = 1; i < D_DEPTH; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
            lft_spd  <= moving_s ? out_sat[0] : '0;
            rght_spd <= moving_s ? out_sat[1] : '0;
        end
    end

endmodule

// File: tb/tb_pid_ctrl_p.sv
// Randomised and directed bench for pid_ctrl_p against an integer reference model.
module tb_pid_ctrl_p;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               moving = 1'b0;
    logic               err_vld = 1'b0;
    logic signed [11:0] error = '0;
    logic [9:0]         frwrd = '0;
    logic signed [10:0] lft0, rght0, lft1, rght1;
    logic               vld0, vld1;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

`ifdef PID_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    always #5 clk = ~clk;

    pid_ctrl_p u_dut (
        .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .error(error),
        .frwrd(frwrd), .lft_spd(lft0), .rght_spd(rght0), .spd_vld(vld0)
    );

    pid_ctrl_p #(.D_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .error(error),
        .frwrd(frwrd), .lft_spd(lft1), .rght_spd(rght1), .spd_vld(vld1)
    );

    // Reference model state, one slot per instance.
    int depth [2] = '{1, 2};
    int m_p [2], m_i [2], m_d [2], m_intg [2];
    int m_hist [2][4];
    int m_vld1 [2], m_vld2 [2], m_pidq [2], m_frq [2], m_mvq [2];
    int e_l [2], e_r [2], e_v [2];

    function automatic int sat(input int v, input int w);
        int hi, lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int es, pid, s, e_in, fr_in;
        e_in  = error;
        fr_in = frwrd;
        es    = sat(e_in, 10);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_p[k] = 0; m_i[k] = 0; m_d[k] = 0; m_intg[k] = 0;
                for (int j = 0; j < 4; j++) m_hist[k][j] = 0;
                m_vld1[k] = 0; m_vld2[k] = 0; m_pidq[k] = 0; m_frq[k] = 0; m_mvq[k] = 0;
                e_l[k] = 0; e_r[k] = 0; e_v[k] = 0;
            end else begin
                pid = m_p[k] + m_i[k] + m_d[k];
`ifdef PID_PIPE_EN
                e_l[k] = m_mvq[k] ? sat(m_frq[k] + (m_pidq[k] >>> 3), 11) : 0;
                e_r[k] = m_mvq[k] ? sat(m_frq[k] - (m_pidq[k] >>> 3), 11) : 0;
                e_v[k] = m_vld2[k];
                m_vld2[k] = m_vld1[k];
                m_pidq[k] = pid;
                m_frq[k]  = fr_in;
                m_mvq[k]  = moving;
`else
                e_l[k] = moving ? sat(fr_in + (pid >>> 3), 11) : 0;
                e_r[k] = moving ? sat(fr_in - (pid >>> 3), 11) : 0;
                e_v[k] = m_vld1[k];
`endif
                m_vld1[k] = err_vld;
                if (err_vld) begin
                    m_p[k] = es * 3;
                    m_i[k] = m_intg[k] >>> 6;
                    m_d[k] = sat(es - m_hist[k][depth[k]-1], 7) * 14;
                    for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                    m_hist[k][0] = es;
                end
                if (!moving) begin
                    m_intg[k] = 0;
                end else if (err_vld) begin
                    s = m_intg[k] + es;
                    if (s <= 131071 && s >= -131072) m_intg[k] = s;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        if (chk_en) begin
            check_eq("lft0", lft0, e_l[0]);
            check_eq("rght0", rght0, e_r[0]);
            check_eq("vld0", vld0, e_v[0]);
            check_eq("lft1", lft1, e_l[1]);
            check_eq("rght1", rght1, e_r[1]);
            check_eq("vld1", vld1, e_v[1]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; err_vld = 1'b0; moving = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // One err_vld pulse, then wait a bounded number of edges for spd_vld.
    task automatic pulse_and_wait(input logic signed [11:0] e, output int lat);
        error = e; err_vld = 1'b1;
        cyc();
        err_vld = 1'b0;
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (vld0) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        frwrd = '0; error = '0;
        do_reset();
        chk_en = 1'b1;
        check_eq("rst_lft", lft0, 0);
        check_eq("rst_rght", rght0, 0);
        check_eq("rst_vld", vld0, 0);
        for (int i = 0; i < 3; i++) cyc();
        check_eq("idle_lft", lft0, 0);
        check_eq("idle_rght", rght0, 0);

        // Single full-scale sample.
        moving = 1'b1; frwrd = 10'd0;
        cyc();
        pulse_and_wait(12'sh7FF, lat);
        check_eq("single_lat", lat, LAT);
        check_eq("single_lft", lft0, 301);
        check_eq("single_rght", rght0, -301);
        cyc();
        check_eq("single_vld_drop", vld0, 0);

        // Same sample with a full forward command saturates the left wheel.
        do_reset();
        moving = 1'b1; frwrd = 10'd1023;
        cyc();
        pulse_and_wait(12'sh7FF, lat);
        check_eq("sat_lft", lft0, 1023);
        check_eq("sat_rght", rght0, 722);

        // Integrator overflow hold.
        do_reset();
        moving = 1'b1; frwrd = 10'd0; error = 12'sd511; err_vld = 1'b1;
        for (int i = 0; i < 260; i++) cyc();
        err_vld = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check_eq("hold_lft", lft0, 447);
        check_eq("hold_rght", rght0, -447);

        // Stop mid-run.
        moving = 1'b0;
        for (int i = 0; i < LAT; i++) cyc();
        check_eq("stop_lft", lft0, 0);
        check_eq("stop_rght", rght0, 0);

        // Negative integrator hold.
        moving = 1'b1; error = -12'sd2048; err_vld = 1'b1;
        for (int i = 0; i < 270; i++) cyc();
        err_vld = 1'b0;

        // Derivative history depth 1 vs 2.
        do_reset();
        moving = 1'b1; frwrd = 10'd0; err_vld = 1'b1;
        error = 12'sd100; cyc();
        error = 12'sd200; cyc();
        error = 12'sd230; cyc();
        err_vld = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check_eq("hist_d1_lft", lft0, 139);
        check_eq("hist_d2_lft", lft1, 197);
        check_eq("hist_d2_rght", rght1, -197);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(199) == 0);
            moving  = ($urandom_range(9) != 0);
            err_vld = $urandom_range(1);
            error   = 12'($urandom);
            frwrd   = 10'($urandom);
            cyc();
        end
        rst = 1'b0; err_vld = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
